// File: rtl/data_register_bank.sv
// data_register_bank: NUM_DR data registers, address register (AR) and
// program counter (PC) with two operand read ports, one bus output port and
// an AR burst engine that steps AR by +/-1 on each memory handshake.
// Optional build macro: DRB_BYPASS_EN (write-through forwarding on reads).
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | engine idle; bus owns AR, burst start accepted
//   S_BURST | engine owns AR; each i_burst_step advances AR, counts down
module data_register_bank #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_DR     = 4,
  parameter int PC_RESET   = 0,
  localparam int SEL_W     = $clog2(NUM_DR + 2)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_wr_en,
  input  logic [SEL_W-1:0]      i_wr_sel,
  input  logic [SEL_W-1:0]      i_rd_sel0,
  input  logic [SEL_W-1:0]      i_rd_sel1,
  input  logic                  i_out_en,
  input  logic [SEL_W-1:0]      i_out_sel,
  input  logic                  i_pc_count_en,
  input  logic                  i_mem_addr_source,
  input  logic                  i_burst_start,
  input  logic [DATA_WIDTH-1:0] i_burst_len,
  input  logic                  i_burst_dir,
  input  logic                  i_burst_step,
  output logic [DATA_WIDTH-1:0] o_operand0,
  output logic [DATA_WIDTH-1:0] o_operand1,
  output logic [DATA_WIDTH-1:0] o_register_output,
  output logic [DATA_WIDTH-1:0] o_direct_addr,
  output logic [DATA_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_program_addr,
  output logic                  o_burst_busy,
  output logic                  o_burst_done
);

  localparam logic [SEL_W-1:0] AR_CODE = SEL_W'(NUM_DR);
  localparam logic [SEL_W-1:0] PC_CODE = SEL_W'(NUM_DR + 1);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] dr_q [NUM_DR];
  logic [DATA_WIDTH-1:0] dr_d [NUM_DR];
  logic [DATA_WIDTH-1:0] ar_q, ar_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
  logic                  dir_q, dir_d;
  logic                  done_q, done_d;
  logic                  busy;

  assign busy = (state_q == S_BURST);

  // Register read mux; unknown codes read as zero.
  function automatic logic [DATA_WIDTH-1:0] reg_value(input logic [SEL_W-1:0] code);
    logic [DATA_WIDTH-1:0] v;
    v = '0;
    for (int k = 0; k < NUM_DR; k++) begin
      if (code == SEL_W'(k)) v = dr_q[k];
    end
    if (code == AR_CODE) v = ar_q;
    if (code == PC_CODE) v = pc_q;
`ifdef DRB_BYPASS_EN
    // Forward only writes that will actually land; AR writes are dropped while busy.
    if (i_wr_en && (code == i_wr_sel) && (code <= PC_CODE) && !((code == AR_CODE) && busy))
      v = i_data;
`else
`endif
    return v;
  endfunction

  // Burst engine next-state: start/count-down control and done pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_burst_start) begin
          if (i_burst_len != '0) begin
            state_d = S_BURST;
            cnt_d   = i_burst_len;
            dir_d   = i_burst_dir;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_BURST: begin
        if (i_burst_step) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == DATA_WIDTH'(1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Register file next values: bus writes, AR stepping, PC counting.
  always_comb begin
    for (int k = 0; k < NUM_DR; k++) begin
      dr_d[k] = dr_q[k];
      if (i_wr_en && (i_wr_sel == SEL_W'(k))) dr_d[k] = i_data;
    end

    ar_d = ar_q;
    if (busy) begin
      if (i_burst_step) ar_d = dir_q ? (ar_q - 1'b1) : (ar_q + 1'b1);
    end else if (i_wr_en && (i_wr_sel == AR_CODE)) begin
      ar_d = i_data;
    end

    pc_d = pc_q;
    if (i_wr_en && (i_wr_sel == PC_CODE)) pc_d = i_data;
    else if (i_pc_count_en)               pc_d = pc_q + 1'b1;
  end

  // State and register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      for (int k = 0; k < NUM_DR; k++) dr_q[k] <= '0;
      ar_q    <= '0;
      pc_q    <= DATA_WIDTH'(PC_RESET);
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      for (int k = 0; k < NUM_DR; k++) dr_q[k] <= dr_d[k];
      ar_q    <= ar_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  // Output ports.
  always_comb begin
    o_operand0        = reg_value(i_rd_sel0);
    o_operand1        = reg_value(i_rd_sel1);
    o_register_output = i_out_en ? reg_value(i_out_sel) : '0;
    o_direct_addr     = ar_q;
    o_program_addr    = pc_q;
    o_mem_addr        = (busy || !i_mem_addr_source) ? ar_q : pc_q;
    o_burst_busy      = busy;
    o_burst_done      = done_q;
  end

endmodule

// File: tb/tb_data_register_bank.sv
// Directed testbench for data_register_bank (DATA_WIDTH=8, NUM_DR=4).
// Codes: 0..3 DRn, 4 AR, 5 PC, 6..7 invalid.
module tb_data_register_bank;

`ifdef DRB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] i_data;
  logic       i_wr_en;
  logic [2:0] i_wr_sel, i_rd_sel0, i_rd_sel1, i_out_sel;
  logic       i_out_en, i_pc_count_en, i_mem_addr_source;
  logic       i_burst_start, i_burst_dir, i_burst_step;
  logic [7:0] i_burst_len;
  logic [7:0] o_operand0, o_operand1, o_register_output;
  logic [7:0] o_direct_addr, o_mem_addr, o_program_addr;
  logic       o_burst_busy, o_burst_done;

  int n_checks = 0;
  int n_fail   = 0;
  int done_pulses = 0;
  int overlap     = 0;

  data_register_bank #(.DATA_WIDTH(8), .NUM_DR(4), .PC_RESET(0)) dut (
    .clk(clk), .rst(rst), .i_data(i_data), .i_wr_en(i_wr_en), .i_wr_sel(i_wr_sel),
    .i_rd_sel0(i_rd_sel0), .i_rd_sel1(i_rd_sel1), .i_out_en(i_out_en), .i_out_sel(i_out_sel),
    .i_pc_count_en(i_pc_count_en), .i_mem_addr_source(i_mem_addr_source),
    .i_burst_start(i_burst_start), .i_burst_len(i_burst_len), .i_burst_dir(i_burst_dir),
    .i_burst_step(i_burst_step), .o_operand0(o_operand0), .o_operand1(o_operand1),
    .o_register_output(o_register_output), .o_direct_addr(o_direct_addr),
    .o_mem_addr(o_mem_addr), .o_program_addr(o_program_addr),
    .o_burst_busy(o_burst_busy), .o_burst_done(o_burst_done)
  );

  always #5 clk = ~clk;

  // Count done pulses and any done-with-busy overlap.
  always @(negedge clk) begin
    if (o_burst_done) done_pulses++;
    if (o_burst_done && o_burst_busy) overlap++;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       wr_en;
    logic [2:0] wr_sel;
    logic [7:0] data;
    logic [2:0] rd0;
    logic [2:0] rd1;
    logic       out_en;
    logic [2:0] out_sel;
    logic [7:0] e0;
    logic [7:0] e1;
    logic [7:0] eout;
  } vec_t;

  vec_t vecs [9];

  // Expected read value with write-through applied when the bypass build is used.
  function automatic logic [7:0] fwd(input vec_t v, input logic [2:0] code, input logic [7:0] e);
    if (BYP && v.wr_en && (code == v.wr_sel) && (code <= 3'd5)) return v.data;
    return e;
  endfunction

  task automatic idle_inputs();
    i_data = '0; i_wr_en = 0; i_wr_sel = '0; i_rd_sel0 = '0; i_rd_sel1 = '0;
    i_out_en = 0; i_out_sel = '0; i_pc_count_en = 0; i_mem_addr_source = 0;
    i_burst_start = 0; i_burst_len = '0; i_burst_dir = 0; i_burst_step = 0;
  endtask

  task automatic cyc();
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    //         wr  sel   data   rd0   rd1   oe  osel  e0     e1     eout
    vecs[0] = '{1, 3'd2, 8'h5A, 3'd2, 3'd0, 1, 3'd2, 8'h00, 8'h00, 8'h00};
    vecs[1] = '{1, 3'd0, 8'h11, 3'd2, 3'd0, 1, 3'd2, 8'h5A, 8'h00, 8'h5A};
    vecs[2] = '{1, 3'd3, 8'hC3, 3'd0, 3'd2, 0, 3'd0, 8'h11, 8'h5A, 8'h00};
    vecs[3] = '{1, 3'd6, 8'hFF, 3'd3, 3'd6, 1, 3'd6, 8'hC3, 8'h00, 8'h00};
    vecs[4] = '{1, 3'd4, 8'h77, 3'd4, 3'd5, 1, 3'd3, 8'h00, 8'h00, 8'hC3};
    vecs[5] = '{1, 3'd5, 8'h20, 3'd4, 3'd1, 1, 3'd4, 8'h77, 8'h00, 8'h77};
    vecs[6] = '{0, 3'd0, 8'h00, 3'd5, 3'd7, 1, 3'd5, 8'h20, 8'h00, 8'h20};
    vecs[7] = '{0, 3'd1, 8'hEE, 3'd1, 3'd3, 1, 3'd0, 8'h00, 8'hC3, 8'h11};
    vecs[8] = '{0, 3'd0, 8'h00, 3'd1, 3'd4, 1, 3'd5, 8'h00, 8'h77, 8'h20};

    idle_inputs();
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    check("rst_ar", o_direct_addr, 8'h00);
    check("rst_pc", o_program_addr, 8'h00);
    check("rst_busy", {7'b0, o_burst_busy}, 8'h00);
    check("rst_done", {7'b0, o_burst_done}, 8'h00);

    // Register read/write table.
    for (int i = 0; i < 9; i++) begin
      cyc();
      i_wr_en = vecs[i].wr_en; i_wr_sel = vecs[i].wr_sel; i_data = vecs[i].data;
      i_rd_sel0 = vecs[i].rd0; i_rd_sel1 = vecs[i].rd1;
      i_out_en = vecs[i].out_en; i_out_sel = vecs[i].out_sel;
      #1;
      check($sformatf("vec%0d_op0", i), o_operand0, fwd(vecs[i], vecs[i].rd0, vecs[i].e0));
      check($sformatf("vec%0d_op1", i), o_operand1, fwd(vecs[i], vecs[i].rd1, vecs[i].e1));
      check($sformatf("vec%0d_out", i), o_register_output,
            vecs[i].out_en ? fwd(vecs[i], vecs[i].out_sel, vecs[i].eout) : 8'h00);
    end

    // PC counting, write priority, wrap. PC = 0x20, AR = 0x77 here.
    for (int i = 0; i < 3; i++) begin
      cyc(); i_pc_count_en = 1; #1;
      check($sformatf("pc_cnt%0d", i), o_program_addr, 8'h20 + 8'(i));
    end
    cyc(); i_wr_en = 1; i_wr_sel = 3'd5; i_data = 8'h40; i_pc_count_en = 1; #1;
    check("pc_plus3", o_program_addr, 8'h23);
    cyc(); i_mem_addr_source = 1; #1;
    check("pc_write_wins", o_program_addr, 8'h40);
    check("mem_addr_pc", o_mem_addr, 8'h40);
    i_mem_addr_source = 0; #1;
    check("mem_addr_ar", o_mem_addr, 8'h77);
    i_wr_en = 1; i_wr_sel = 3'd5; i_data = 8'hFF;
    cyc(); i_pc_count_en = 1; #1;
    check("pc_ff", o_program_addr, 8'hFF);
    cyc(); #1;
    check("pc_wrap", o_program_addr, 8'h00);

    // Burst up from 0xFE, len 3, step every cycle; AR write during burst dropped.
    i_wr_en = 1; i_wr_sel = 3'd4; i_data = 8'hFE;
    cyc(); i_burst_start = 1; i_burst_len = 8'd3; i_burst_dir = 0; #1;
    check("b3_ar_start", o_direct_addr, 8'hFE);
    cyc(); i_burst_step = 1; i_wr_en = 1; i_wr_sel = 3'd4; i_data = 8'h33;
    i_mem_addr_source = 1; i_rd_sel0 = 3'd4; #1;
    check("b3_busy", {7'b0, o_burst_busy}, 8'h01);
    check("b3_memaddr_forced", o_mem_addr, 8'hFE);
    check("b3_op0_ar_nobypass", o_operand0, 8'hFE);
    cyc(); i_burst_step = 1; #1;
    check("b3_ar_ff", o_direct_addr, 8'hFF);
    cyc(); i_burst_step = 1; #1;
    check("b3_ar_00", o_direct_addr, 8'h00);
    check("b3_no_early_done", {7'b0, o_burst_done}, 8'h00);
    cyc(); i_burst_step = 1; #1;
    check("b3_ar_01", o_direct_addr, 8'h01);
    check("b3_done", {7'b0, o_burst_done}, 8'h01);
    check("b3_idle", {7'b0, o_burst_busy}, 8'h00);
    cyc(); #1;
    check("b3_done_1cyc", {7'b0, o_burst_done}, 8'h00);
    check("b3_idle_step_ignored", o_direct_addr, 8'h01);

    // Burst down, len 2, gapped steps; start/dir ignored mid-burst.
    i_burst_start = 1; i_burst_len = 8'd2; i_burst_dir = 1;
    cyc(); #1;
    check("b2_busy", {7'b0, o_burst_busy}, 8'h01);
    cyc(); #1;
    check("b2_hold0", o_direct_addr, 8'h01);
    cyc(); i_burst_step = 1; #1;
    check("b2_hold1", o_direct_addr, 8'h01);
    cyc(); #1;
    check("b2_ar_00", o_direct_addr, 8'h00);
    check("b2_busy_held", {7'b0, o_burst_busy}, 8'h01);
    cyc(); i_burst_start = 1; i_burst_len = 8'd5; i_burst_dir = 0; #1;
    check("b2_gap", o_direct_addr, 8'h00);
    cyc(); i_burst_step = 1; #1;
    check("b2_done_not_yet", {7'b0, o_burst_done}, 8'h00);
    cyc(); #1;
    check("b2_ar_ff", o_direct_addr, 8'hFF);
    check("b2_done", {7'b0, o_burst_done}, 8'h01);
    check("b2_idle", {7'b0, o_burst_busy}, 8'h00);

    // Zero-length burst: done next cycle, never busy.
    i_burst_start = 1; i_burst_len = 8'd0;
    cyc(); #1;
    check("b0_done", {7'b0, o_burst_done}, 8'h01);
    check("b0_busy", {7'b0, o_burst_busy}, 8'h00);
    cyc(); #1;
    check("b0_done_clear", {7'b0, o_burst_done}, 8'h00);

    // Reset mid-burst with two steps remaining.
    i_wr_en = 1; i_wr_sel = 3'd4; i_data = 8'h10;
    cyc(); i_burst_start = 1; i_burst_len = 8'd4; #1;
    cyc(); i_burst_step = 1; #1;
    cyc(); i_burst_step = 1; #1;
    cyc(); rst = 1; #1;
    check("rstb_ar_before", o_direct_addr, 8'h12);
    cyc(); rst = 0; i_rd_sel0 = 3'd2; i_out_en = 0; i_out_sel = 3'd4; #1;
    check("rstb_busy", {7'b0, o_burst_busy}, 8'h00);
    check("rstb_ar", o_direct_addr, 8'h00);
    check("rstb_done", {7'b0, o_burst_done}, 8'h00);
    check("rstb_dr2", o_operand0, 8'h00);
    check("out_en_off", o_register_output, 8'h00);
    cyc(); #1;
    check("rstb_no_done", {7'b0, o_burst_done}, 8'h00);

    check("done_pulse_count", 8'(done_pulses), 8'd3);
    check("done_busy_overlap", 8'(overlap), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
